imem_readback: RTL and testbench

Sequential reader for the 1024x32 instruction memory, the counterpart to the instruction-load write path (rw=0, PC_write, instruction_in). On a start pulse it reads an inclusive address range word by word. Each 32-bit word is serialized little-endian onto an 8-bit valid/ready byte stream for dump/debug. It sits beside the instruction memory and shares the memory read port with the fetch stage while the core is held in reset.

---
 rtl/imem_readback_if.sv | 29 ++
 rtl/imem_readback.sv | 170 +++++++++++++++++
 tb/tb_imem_readback.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_readback_if.sv
// Bus bundle for imem_readback: start/range request, instruction-memory read port and byte stream.
// master = readback engine, slave = memory/consumer side.
interface imem_readback_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_BYTES = 4
);
  logic                    start;
  logic [ADDR_WIDTH-1:0]   start_addr;
  logic [ADDR_WIDTH-1:0]   end_addr;
  logic                    mem_rd_en;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [8*WORD_BYTES-1:0] mem_rdata;
  logic [7:0]              byte_out;
  logic                    byte_valid;
  logic                    byte_ready;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    input  start, start_addr, end_addr, mem_rdata, byte_ready,
    output mem_rd_en, mem_addr, byte_out, byte_valid, busy, done, err
  );

  modport slave (
    output start, start_addr, end_addr, mem_rdata, byte_ready,
    input  mem_rd_en, mem_addr, byte_out, byte_valid, busy, done, err
  );
endinterface

// File: rtl/imem_readback.sv
// Reads an inclusive instruction-memory range and streams each word little-endian as bytes (valid/ready).
// Optional trailing XOR checksum byte when IMEM_READBACK_CHECKSUM_EN is defined.
module imem_readback #(
  parameter int ADDR_WIDTH = 10,
  parameter int WORD_BYTES = 4
) (
  input  logic          clock,
  input  logic          reset,
  imem_readback_if.master bus
);

  localparam int DW = 8 * WORD_BYTES;
  localparam int CW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(WORD_BYTES - 1);

`ifdef IMEM_READBACK_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, FINISH, CSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, FINISH} state_t;
`endif

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [ADDR_WIDTH-1:0] end_q, end_nxt;
  logic [DW-1:0]         shift, shift_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
`ifdef IMEM_READBACK_CHECKSUM_EN
  logic [7:0]            csum, csum_nxt;
`endif
  logic                  good_start, bad_start, fire;

  logic                  mem_rd_en_q, mem_rd_en_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_nxt;
  logic [7:0]            byte_out_q, byte_out_nxt;
  logic                  byte_valid_q, byte_valid_nxt;
  logic                  busy_q, busy_nxt;
  logic                  done_q, done_nxt;
  logic                  err_q, err_nxt;

  assign fire = byte_valid_q && bus.byte_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      addr         <= '0;
      end_q        <= '0;
      shift        <= '0;
      cnt          <= '0;
`ifdef IMEM_READBACK_CHECKSUM_EN
      csum         <= '0;
`endif
      mem_rd_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state        <= state_nxt;
      addr         <= addr_nxt;
      end_q        <= end_nxt;
      shift        <= shift_nxt;
      cnt          <= cnt_nxt;
`ifdef IMEM_READBACK_CHECKSUM_EN
      csum         <= csum_nxt;
`endif
      mem_rd_en_q  <= mem_rd_en_nxt;
      mem_addr_q   <= mem_addr_nxt;
      byte_out_q   <= byte_out_nxt;
      byte_valid_q <= byte_valid_nxt;
      busy_q       <= busy_nxt;
      done_q       <= done_nxt;
      err_q        <= err_nxt;
    end
  end

  // Equality compare on the last address keeps end_addr = all-ones from wrapping.
  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    end_nxt    = end_q;
    shift_nxt  = shift;
    cnt_nxt    = cnt;
`ifdef IMEM_READBACK_CHECKSUM_EN
    csum_nxt   = csum;
`endif
    good_start = 1'b0;
    bad_start  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.end_addr >= bus.start_addr) begin
            good_start = 1'b1;
            addr_nxt   = bus.start_addr;
            end_nxt    = bus.end_addr;
`ifdef IMEM_READBACK_CHECKSUM_EN
            csum_nxt   = '0;
`endif
            state_nxt  = READ;
          end else begin
            bad_start = 1'b1;
          end
        end
      end
      READ:    state_nxt = CAPTURE;
      CAPTURE: begin
        shift_nxt = bus.mem_rdata;
        cnt_nxt   = '0;
        state_nxt = SEND;
      end
      SEND: begin
        if (fire) begin
          shift_nxt = shift >> 8;
          cnt_nxt   = cnt + 1'b1;
`ifdef IMEM_READBACK_CHECKSUM_EN
          csum_nxt  = csum ^ shift[7:0];
`endif
          if (cnt == LAST_BYTE) begin
            if (addr == end_q) begin
`ifdef IMEM_READBACK_CHECKSUM_EN
              state_nxt = CSUM;
`else
              state_nxt = FINISH;
`endif
            end else begin
              addr_nxt  = addr + 1'b1;
              state_nxt = READ;
            end
          end
        end
      end
`ifdef IMEM_READBACK_CHECKSUM_EN
      CSUM:    if (fire) state_nxt = FINISH;
`endif
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight from a flop.
  always_comb begin
    mem_rd_en_nxt  = (state_nxt == READ);
    mem_addr_nxt   = (state_nxt == READ) ? addr_nxt : mem_addr_q;
    byte_out_nxt   = byte_out_q;
    byte_valid_nxt = (state_nxt == SEND);
    busy_nxt       = (state_nxt == READ) || (state_nxt == CAPTURE) || (state_nxt == SEND);
    if (state_nxt == SEND) byte_out_nxt = shift_nxt[7:0];
`ifdef IMEM_READBACK_CHECKSUM_EN
    if (state_nxt == CSUM) begin
      byte_out_nxt   = csum_nxt;
      byte_valid_nxt = 1'b1;
      busy_nxt       = 1'b1;
    end
`endif
    done_nxt = (state_nxt == FINISH) || bad_start;
    err_nxt  = err_q;
    if (bad_start)       err_nxt = 1'b1;
    else if (good_start) err_nxt = 1'b0;
  end

  assign bus.mem_rd_en  = mem_rd_en_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.byte_out   = byte_out_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_readback.sv
// Scoreboard bench for imem_readback: expected reads/bytes queued at start, popped as the DUT emits them.
module tb_imem_readback;
  localparam int AW = 10;
  localparam int WB = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  imem_readback_if #(.ADDR_WIDTH(AW), .WORD_BYTES(WB)) bus ();

  imem_readback #(.ADDR_WIDTH(AW), .WORD_BYTES(WB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0]   mem [0:1023];
  logic [7:0]    exp_bytes [$];
  logic [AW-1:0] exp_rd [$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_bytes = 0;
  logic [7:0]    last_byte = '0;
  bit            ready_mode = 1'b0;
  bit            prev_hold = 1'b0;
  logic [7:0]    prev_byte = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clock) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

  initial begin
    bus.byte_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      bus.byte_ready = ready_mode ? ~bus.byte_ready : 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_vld", {31'd0, bus.byte_valid}, 32'd1);
          check("hold_dat", {24'd0, bus.byte_out}, {24'd0, prev_byte});
        end
        if (bus.mem_rd_en) begin
          if (exp_rd.size() == 0) check("extra_read", {22'd0, bus.mem_addr}, 32'hFFFF_FFFF);
          else check("rd_addr", {22'd0, bus.mem_addr}, {22'd0, exp_rd.pop_front()});
        end
        if (bus.byte_valid && bus.byte_ready) begin
          if (exp_bytes.size() == 0) check("extra_byte", {24'd0, bus.byte_out}, 32'hFFFF_FFFF);
          else check("byte", {24'd0, bus.byte_out}, {24'd0, exp_bytes.pop_front()});
          last_byte = bus.byte_out;
          n_bytes++;
        end
        prev_hold = bus.byte_valid && !bus.byte_ready;
        prev_byte = bus.byte_out;
      end
    end
  end

  task automatic push_range(input int sa, input int ea, output int nexp);
    logic [7:0] x;
    logic [31:0] w;
    x = '0;
    nexp = 0;
    for (int a = sa; a <= ea; a++) begin
      exp_rd.push_back(AW'(a));
      w = mem[a];
      for (int b = 0; b < WB; b++) begin
        exp_bytes.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
        nexp++;
      end
    end
`ifdef IMEM_READBACK_CHECKSUM_EN
    exp_bytes.push_back(x);
    nexp++;
`endif
  endtask

  task automatic pulse_start(input int sa, input int ea);
    @(posedge clock);
    #1;
    bus.start = 1'b1;
    bus.start_addr = AW'(sa);
    bus.end_addr = AW'(ea);
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.end_addr = '0;
  endtask

  task automatic run_range(input int sa, input int ea, input bit poke, output int lat);
    int base, nexp;
    bit got;
    base = n_bytes;
    got = 1'b0;
    lat = 0;
    push_range(sa, ea, nexp);
    pulse_start(sa, ea);
    for (int k = 1; k <= 400; k++) begin
      @(negedge clock);
      // A start while busy must neither restart nor change the range.
      if (poke && k == 4) begin
        bus.start = 1'b1;
        bus.start_addr = AW'(20);
        bus.end_addr = AW'(30);
      end
      if (poke && k == 5) bus.start = 1'b0;
      if (bus.done) begin
        got = 1'b1;
        lat = k;
        break;
      end
    end
    if (!got) begin
      check("timeout_done", 32'd0, 32'd1);
    end else begin
      check("busy_at_done", {31'd0, bus.busy}, 32'd0);
      check("err_at_done", {31'd0, bus.err}, 32'd0);
      check("nbytes", n_bytes - base, nexp);
      check("rd_left", exp_rd.size(), 32'd0);
    end
    @(negedge clock);
    check("done_pulse", {31'd0, bus.done}, 32'd0);
    @(negedge clock);
    exp_rd.delete();
    exp_bytes.delete();
  endtask

  initial begin
    int lat, base;
    bit got;
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int lat, base;
    bit got;
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.end_addr = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'h9E37_79B1;

    repeat (3) @(negedge clock);
    check("rst_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    check("rst_addr", {22'd0, bus.mem_addr}, 32'd0);
    check("rst_byte", {24'd0, bus.byte_out}, 32'd0);
    check("rst_valid", {31'd0, bus.byte_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Single word, full-rate consumer.
    mem[1] = 32'h0002_8083;
    run_range(1, 1, 1'b0, lat);
    check("t1_latency", lat, 32'd7);

    // Two words with a consumer that stalls every other cycle.
    mem[7] = 32'h0031_70B3;
    mem[8] = 32'h0022_0563;
    ready_mode = 1'b1;
    run_range(7, 8, 1'b1, lat);
    ready_mode = 1'b0;
    @(negedge clock);

    // Inverted range: error with a single done pulse and no read.
    pulse_start(12, 5);
    @(negedge clock);
    check("t3_done", {31'd0, bus.done}, 32'd1);
    check("t3_err", {31'd0, bus.err}, 32'd1);
    check("t3_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clock);
    check("t3_done_pulse", {31'd0, bus.done}, 32'd0);
    check("t3_err_sticky", {31'd0, bus.err}, 32'd1);
    run_range(1, 1, 1'b0, lat);

    // Top of the address space must stop on the compare, not wrap.
    mem[1022] = 32'hA1B2_C3D4;
    mem[1023] = 32'h1122_3344;
    run_range(1022, 1023, 1'b0, lat);

    // Reset in the middle of the second word.
    mem[2] = 32'hDEAD_BEEF;
    mem[3] = 32'h0BAD_F00D;
    base = n_bytes;
    push_range(1, 3, lat);
    pulse_start(1, 3);
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (n_bytes >= base + 5) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("timeout_t5", 32'd0, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("t5_valid", {31'd0, bus.byte_valid}, 32'd0);
    check("t5_busy", {31'd0, bus.busy}, 32'd0);
    check("t5_done", {31'd0, bus.done}, 32'd0);
    check("t5_rd_en", {31'd0, bus.mem_rd_en}, 32'd0);
    exp_rd.delete();
    exp_bytes.delete();
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("t5_idle_busy", {31'd0, bus.busy}, 32'd0);
    check("t5_idle_done", {31'd0, bus.done}, 32'd0);
    check("t5_idle_valid", {31'd0, bus.byte_valid}, 32'd0);
    run_range(1, 1, 1'b0, lat);

`ifdef IMEM_READBACK_CHECKSUM_EN
    mem[2] = 32'h0000_0000;
    mem[3] = 32'h0000_00FF;
    run_range(2, 3, 1'b0, lat);
    check("t6_csum_byte", {24'd0, last_byte}, 32'h0000_00FF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
